regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file for the pipelined core, replacing the single-cycle two-port file. Width, depth and read-port count are generalised. Reads are registered with 1-cycle latency, x0 is hardwired to zero, and a per-register pending-write scoreboard supports hazard detection. It sits between decode (reads, issue marking) and writeback (single write port). All state updates on the rising clock edge.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, 2..64; AW = $clog2(NREGS)
- NREAD, 2, number of read ports, 1..4
- RESET_INDEX, 0, reset value select: 0 means every register resets to 0; 1 means register i resets to i, zero-extended (debug preload)

Ports:
- clk  in  1  clock; all sequential logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- rs_en  in  NREAD  per-port read enable
- rs_addr  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rs_data  out  NREAD*XLEN  registered read data, packed the same way
- rs_busy  out  NREAD  registered pending-write flag for the address read on each port
- we  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- busy_set  in  1  issue strobe: marks busy_addr as pending
- busy_addr  in  AW  register being marked pending

## Operation
- Storage is NREGS x XLEN flops plus NREGS busy bits.
- Register 0 always reads 0 and never reads busy.
  - Writes to register 0 are dropped.
  - busy_set to register 0 is dropped.
- Write: when we=1 and wr_addr≠0, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0 at the rising edge.
- Issue: when busy_set=1 and busy_addr≠0, busy[busy_addr] <= 1.
- Simultaneous write and busy_set to the same register: data is written and busy ends at 1, because the set wins (a new producer has issued).
- Read port k:
  - When rs_en[k]=1, rs_data[k] <= value and rs_busy[k] <= busy flag for rs_addr[k].
  - When rs_en[k]=0, both outputs hold their previous values.
- Multiple ports reading the same address return identical data.
- Reset (reset=0) asserts immediately, independent of clk:
  - Array is loaded per RESET_INDEX.
  - All busy bits clear.
  - rs_data = 0 and rs_busy = 0.
  - Inputs are ignored while reset is held. The first update occurs on the first rising edge after reset deasserts.
- Reset asserted mid-operation discards any in-flight write or issue in that cycle.

## Timing
- Read latency: 1 cycle. The address presented in cycle N appears on rs_data/rs_busy after edge N+1.
- Write latency: data is visible to a read issued in cycle N+1 after a write in cycle N, without bypass.
- busy_set in cycle N: a read issued in cycle N+1 sees busy=1.
- Same-cycle read/write of the same nonzero address is governed by the Configuration section.
- No handshake: all strobes are single-cycle qualifiers and are sampled on every rising edge.

## Configuration
- Macro: REGFILE_BYPASS_EN
- Defined: a read in cycle N whose rs_addr equals wr_addr with we=1 (address≠0) captures wr_data. rs_busy reflects the post-update busy state, i.e. busy_set to the same address in the same cycle gives 1, otherwise 0.
- Undefined: a same-cycle read captures the pre-write array value and the pre-update busy bit. The pipeline must then stall one cycle or forward externally.
- Register-0 behaviour is identical in both builds.

## Test plan
- Reset: pulse reset low asynchronously mid-cycle with RESET_INDEX=1, then read all addresses. Required response: rs_data=i for i=1..31, reg0=0, rs_busy=0, and outputs=0 during reset.
- Write/read: write 0xDEADBEEF to r5 in cycle 0 and read r5 on both ports in cycle 1. Required response: both ports show 0xDEADBEEF after the cycle-2 edge.
- x0: write 0xFFFFFFFF to r0 with busy_set r0, then read r0. Required response: rs_data=0 and rs_busy=0.
- Scoreboard: busy_set r7 in cycle 0, read r7 in cycle 1, then write r7=0x12 with busy_set r7 in cycle 2 and read in cycle 3. Required response: busy=1, then data=0x12 with busy=1. A write alone to r7 in cycle 4, read in cycle 5, gives busy=0.
- Bypass: read r9 while writing r9=0xA5A5 in the same cycle, with old value 0x9. Required response: rs_data=0xA5A5 with REGFILE_BYPASS_EN, 0x9 without.
- Hold: set rs_en=0 on port 1 while its address changes. Required response: rs_data[1] and rs_busy[1] remain unchanged for all such cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with registered reads, hardwired x0 and pending-write scoreboard
//
// Ports:
//    clk       rising-edge clock
//    reset     asynchronous active-low reset
//    rs_en     per-port read enable
//    rs_addr   packed read addresses, port k at [k*AW +: AW]
//    rs_data   registered read data, port k at [k*XLEN +: XLEN]
//    rs_busy   registered pending-write flag per read port
//    we        write enable
//    wr_addr   write address
//    wr_data   write data
//    busy_set  issue strobe marking busy_addr pending
//    busy_addr register being marked pending
//
// Build option REGFILE_BYPASS_EN: a read of the register being written
// in the same cycle captures the write data and the post-update busy bit.
// Without it, same-cycle reads see the pre-write value and busy bit.
module regfile_mp #(
   parameter int XLEN        = 32,
   parameter int NREGS       = 32,
   parameter int NREAD       = 2,
   parameter int RESET_INDEX = 0,
   localparam int AW         = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD-1:0]      rs_en,
   input  logic [NREAD*AW-1:0]   rs_addr,
   output logic [NREAD*XLEN-1:0] rs_data,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  we,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  busy_set,
   input  logic [AW-1:0]         busy_addr
);
   logic [XLEN-1:0]  r_mem [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [XLEN-1:0]  r_rs_data [NREAD];
   logic [NREAD-1:0] r_rs_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [XLEN-1:0]  w_rd_data [NREAD];
   logic [NREAD-1:0] w_rd_busy;

   // A same-cycle issue wins over the write's clear: a new producer is in flight.
   always_comb begin
      w_busy_nxt = '0;
      for (int i = 1; i < NREGS; i++)
         w_busy_nxt[i] = (busy_set && busy_addr == AW'(i)) || (r_busy[i] && !(we && wr_addr == AW'(i)));
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra = rs_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic w_hit;
      assign w_hit        = we && wr_addr == w_ra && w_ra != '0;
      assign w_rd_data[k] = w_hit ? wr_data : r_mem[w_ra];
      assign w_rd_busy[k] = w_busy_nxt[w_ra];
`else
      assign w_rd_data[k] = r_mem[w_ra];
      assign w_rd_busy[k] = r_busy[w_ra];
`endif
      assign rs_data[k*XLEN +: XLEN] = r_rs_data[k];
   end

   assign rs_busy = r_rs_busy;

   // Entry 0 is loaded with zero at reset and never written, so it reads as zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            r_mem[i] <= (RESET_INDEX == 1) ? XLEN'(i) : '0;
         r_busy    <= '0;
         for (int k = 0; k < NREAD; k++)
            r_rs_data[k] <= '0;
         r_rs_busy <= '0;
      end else begin
         if (we && wr_addr != '0)
            r_mem[wr_addr] <= wr_data;
         r_busy <= w_busy_nxt;
         for (int k = 0; k < NREAD; k++)
            if (rs_en[k]) begin
               r_rs_data[k] <= w_rd_data[k];
               r_rs_busy[k] <= w_rd_busy[k];
            end
      end
   end
endmodule
